// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the
// core/debug unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_DBG  = 2'd2
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transfer watchdog: counts stalled cycles
// and flags the cycle that reaches the limit.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // clear on grant, count each stalled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between core and debug
// loader for one unified-memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_q;
  logic       last_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic gnt_c;
  logic gnt_d;
  logic in_xfer;
  logic run;
  logic expired;
  logic done;
  logic is_core;
  logic is_dbg;

  assign in_xfer = (state_q != ST_IDLE);
  assign is_core = (state_q == ST_CORE);
  assign is_dbg  = (state_q == ST_DBG);
  assign run     = in_xfer && !m_ack;
  assign done    = m_ack || expired;

  // arbitration and next-state selection
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_c   = 1'b0;
    gnt_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          (c_req && d_req): begin
            if (last_q == OWN_DBG) begin
              gnt_c = 1'b1;
            end else begin
              gnt_d = 1'b1;
            end
          end
          (c_req && !d_req): gnt_c = 1'b1;
          (!c_req && d_req): gnt_d = 1'b1;
          default: ;
        endcase
        if (gnt_c) begin
          state_d = ST_CORE;
        end else if (gnt_d) begin
          state_d = ST_DBG;
        end
      end
      ST_CORE: begin
        if (done) begin
          state_d = ST_IDLE;
          last_d  = OWN_CORE;
        end
      end
      ST_DBG: begin
        if (done) begin
          state_d = ST_IDLE;
          last_d  = OWN_DBG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_DBG;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // capture the winner's request at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (gnt_c) begin
      addr_q  <= c_addr;
      we_q    <= c_we;
      wdata_q <= c_wdata;
    end else if (gnt_d) begin
      addr_q  <= d_addr;
      we_q    <= d_we;
      wdata_q <= d_wdata;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (gnt_c || gnt_d),
    .run     (run),
    .expired (expired)
  );

  assign m_req   = in_xfer;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign busy  = in_xfer;
  assign owner = is_dbg;

  // a real ack wins over a same-cycle expiry
  assign c_ack   = is_core && done;
  assign c_err   = is_core && expired;
  assign c_rdata = (is_core && m_ack) ? m_rdata : '0;

  assign d_ack   = is_dbg && done;
  assign d_err   = is_dbg && expired;
  assign d_rdata = (is_dbg && m_ack) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a
// latency-programmable memory responder.
module tb_mem_arbiter;

  localparam logic [31:0] WR_BUS = 32'h5A5A_5A5A;
  localparam logic [31:0] NOISE  = 32'hA5A5_0F0F;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, c_ack, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, owner;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_lat = 3;
  bit          stray = 1'b0;
  logic [31:0] mem [logic [31:0]];

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ack   (c_ack),
    .c_rdata (c_rdata),
    .c_err   (c_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .busy    (busy),
    .owner   (owner)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1);
  end

  function automatic logic [31:0] rd_model(
    input logic [31:0] a
  );
    return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // memory: ack in m_req cycle mem_lat+1
  initial begin
    int k;
    k = 0;
    m_ack = 1'b0;
    m_rdata = NOISE;
    mem[32'h100] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0;
        m_ack = 1'b0;
        m_rdata = NOISE;
      end else if (m_req) begin
        k++;
        if (mem_lat > 0 && k == mem_lat + 1) begin
          m_ack = 1'b1;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            m_rdata = WR_BUS;
          end else begin
            m_rdata = mem.exists(m_addr) ?
              mem[m_addr] : ~m_addr;
          end
        end else begin
          m_ack = 1'b0;
          m_rdata = NOISE;
        end
      end else begin
        k = 0;
        m_ack = stray;
        m_rdata = NOISE;
      end
    end
  end

  task automatic wait_ack(
    input int bound,
    output int n,
    output bit hit
  );
    n = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clk);
      #1;
      n++;
      hit = c_ack || d_ack;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mreq got=%b exp=0", m_req);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    n_cmp++;
    if ({c_ack, d_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_ack got=%b%b exp=00",
        c_ack, d_ack);
    end
    n_cmp++;
    if ({c_err, d_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_err got=%b%b exp=00",
        c_err, d_err);
    end
    n_cmp++;
    if ({m_we, m_addr, m_wdata} !== 65'd0) begin
      n_bad++;
      $display("FAIL rst_regs got=%b/%h/%h exp=0",
        m_we, m_addr, m_wdata);
    end
    n_cmp++;
    if (owner !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_owner got=%b exp=0", owner);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_core_read();
    int n;
    bit hit;
    exp_t e;
    logic [33:0] got, want;
    mem_lat = 3;
    @(negedge clk);
    c_req = 1'b1;
    c_we = 1'b0;
    c_addr = 32'h100;
    expq.push_back('{1'b0, 1'b0, rd_model(32'h100)});
    #1;
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_early got=%b exp=0", m_req);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_req, owner, m_addr} !== {2'b10, 32'h100})
    begin
      n_bad++;
      $display("FAIL rd_grant got=%b%b/%h exp=10/100",
        m_req, owner, m_addr);
    end
    n_cmp++;
    if (c_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL rd_gate got=%h exp=0", c_rdata);
    end
    wait_ack(10, n, hit);
    n_cmp++;
    if (!hit || n != 3) begin
      n_bad++;
      $display("FAIL rd_lat got=%0d/%b exp=3/1", n, hit);
    end
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL rd_sb got=empty exp=entry");
    end else begin
      e = expq.pop_front();
      got = {d_ack, d_ack ? d_err : c_err,
        d_ack ? d_rdata : c_rdata};
      want = {e.port, e.err, e.rdata};
      if (got !== want) begin
        n_bad++;
        $display("FAIL rd_sb got=%h exp=%h", got, want);
      end
    end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_tie();
    int n;
    bit hit;
    exp_t e;
    logic [33:0] got, want;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_lat = 1;
    @(negedge clk);
    c_req = 1'b1;
    d_req = 1'b1;
    c_we = 1'b0;
    d_we = 1'b0;
    c_addr = 32'h200;
    d_addr = 32'h300;
    expq.push_back('{1'b0, 1'b0, rd_model(32'h200)});
    expq.push_back('{1'b1, 1'b0, rd_model(32'h300)});
    #1;
    for (int i = 0; i < 2; i++) begin
      wait_ack(10, n, hit);
      n_cmp++;
      if (!hit || n != 2 - i) begin
        n_bad++;
        $display("FAIL tie_lat%0d got=%0d/%b exp=%0d/1",
          i, n, hit, 2 - i);
      end
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL tie_sb got=empty exp=entry");
      end else begin
        e = expq.pop_front();
        got = {d_ack, d_ack ? d_err : c_err,
          d_ack ? d_rdata : c_rdata};
        want = {e.port, e.err, e.rdata};
        if (got !== want) begin
          n_bad++;
          $display("FAIL tie_sb got=%h exp=%h",
            got, want);
        end
      end
      @(negedge clk);
      c_req = 1'b0;
      if (i == 1) d_req = 1'b0;
      #1;
      n_cmp++;
      if ({busy, d_ack} !== 2'b00) begin
        n_bad++;
        $display("FAIL tie_gap got=%b%b exp=00",
          busy, d_ack);
      end
      if (i == 0) begin
        @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, owner, m_addr} !== {2'b11, 32'h300})
        begin
          n_bad++;
          $display("FAIL tie_dbg got=%b%b/%h exp=11/300",
            busy, owner, m_addr);
        end
      end
    end
  endtask

  task automatic test_contention();
    int n;
    bit hit;
    bit was_d;
    int ci, di;
    exp_t e;
    logic [33:0] got, want;
    mem_lat = 1;
    for (int k = 0; k < 3; k++) begin
      expq.push_back('{1'b0, 1'b0,
        rd_model(32'h1000 + 32'(4 * k))});
      expq.push_back('{1'b1, 1'b0,
        rd_model(32'h2000 + 32'(4 * k))});
    end
    ci = 0;
    di = 0;
    @(negedge clk);
    c_req = 1'b1;
    d_req = 1'b1;
    c_addr = 32'h1000;
    d_addr = 32'h2000;
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_ack(10, n, hit);
      n_cmp++;
      if (!hit) begin
        n_bad++;
        $display("FAIL rr_wait%0d got=none exp=ack", i);
      end else if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL rr_sb got=empty exp=entry");
      end else begin
        e = expq.pop_front();
        got = {d_ack, d_ack ? d_err : c_err,
          d_ack ? d_rdata : c_rdata};
        want = {e.port, e.err, e.rdata};
        if (got !== want) begin
          n_bad++;
          $display("FAIL rr_sb%0d got=%h exp=%h",
            i, got, want);
        end
      end
      was_d = d_ack;
      @(negedge clk);
      if (was_d) begin
        di++;
        d_addr = 32'h2000 + 32'(4 * di);
      end else begin
        ci++;
        c_addr = 32'h1000 + 32'(4 * ci);
      end
      if (i == 5) begin
        c_req = 1'b0;
        d_req = 1'b0;
      end
      #1;
    end
  endtask

  task automatic test_timeout();
    int n;
    bit hit;
    exp_t e;
    logic [33:0] got, want;
    mem_lat = 0;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h500;
    d_wdata = 32'hCAFE_0001;
    expq.push_back('{1'b1, 1'b1, 32'd0});
    #1;
    wait_ack(20, n, hit);
    n_cmp++;
    if (!hit || n != 8) begin
      n_bad++;
      $display("FAIL to_lat got=%0d/%b exp=8/1", n, hit);
    end
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL to_sb got=empty exp=entry");
    end else begin
      e = expq.pop_front();
      got = {d_ack, d_ack ? d_err : c_err,
        d_ack ? d_rdata : c_rdata};
      want = {e.port, e.err, e.rdata};
      if (got !== want) begin
        n_bad++;
        $display("FAIL to_sb got=%h exp=%h", got, want);
      end
    end
    stray = 1'b1;
    @(negedge clk);
    d_req = 1'b0;
    d_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({m_ack, busy, c_ack, d_ack} !== 4'b1000) begin
        n_bad++;
        $display("FAIL to_stray%0d got=%b%b%b%b exp=1000",
          i, m_ack, busy, c_ack, d_ack);
      end
      @(negedge clk);
    end
    stray = 1'b0;
    mem_lat = 7;
    @(negedge clk);
    c_req = 1'b1;
    c_we = 1'b0;
    c_addr = 32'h600;
    expq.push_back('{1'b0, 1'b0, rd_model(32'h600)});
    #1;
    wait_ack(20, n, hit);
    n_cmp++;
    if (!hit || n != 8) begin
      n_bad++;
      $display("FAIL edge_lat got=%0d/%b exp=8/1", n, hit);
    end
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL edge_sb got=empty exp=entry");
    end else begin
      e = expq.pop_front();
      got = {d_ack, d_ack ? d_err : c_err,
        d_ack ? d_rdata : c_rdata};
      want = {e.port, e.err, e.rdata};
      if (got !== want) begin
        n_bad++;
        $display("FAIL edge_sb got=%h exp=%h", got, want);
      end
    end
    @(negedge clk);
    c_req = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit;
    exp_t e;
    logic [33:0] got, want;
    mem_lat = 0;
    @(negedge clk);
    c_req = 1'b1;
    c_we = 1'b1;
    c_addr = 32'h700;
    c_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h800;
    #1;
    n_cmp++;
    if ({m_req, owner} !== 2'b10) begin
      n_bad++;
      $display("FAIL rm_pre got=%b%b exp=10", m_req, owner);
    end
    #1 rst_n = 1'b0;
    c_req = 1'b0;
    #1;
    n_cmp++;
    if ({m_req, busy, c_ack, c_err, d_ack} !== 5'b0)
    begin
      n_bad++;
      $display("FAIL rm_async got=%b%b%b%b%b exp=00000",
        m_req, busy, c_ack, c_err, d_ack);
    end
    mem_lat = 1;
    expq.push_back('{1'b1, 1'b0, rd_model(32'h800)});
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_req, owner, m_addr} !== {2'b11, 32'h800})
    begin
      n_bad++;
      $display("FAIL rm_grant got=%b%b/%h exp=11/800",
        m_req, owner, m_addr);
    end
    wait_ack(10, n, hit);
    n_cmp++;
    if (!hit || n != 1) begin
      n_bad++;
      $display("FAIL rm_lat got=%0d/%b exp=1/1", n, hit);
    end
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL rm_sb got=empty exp=entry");
    end else begin
      e = expq.pop_front();
      got = {d_ack, d_ack ? d_err : c_err,
        d_ack ? d_rdata : c_rdata};
      want = {e.port, e.err, e.rdata};
      if (got !== want) begin
        n_bad++;
        $display("FAIL rm_sb got=%h exp=%h", got, want);
      end
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_cmp++;
    if (mem.exists(32'h700) !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_replay got=written exp=absent");
    end
  endtask

  task automatic test_write_path();
    exp_t e;
    logic [33:0] got, want;
    mem_lat = 3;
    @(negedge clk);
    c_req = 1'b1;
    c_we = 1'b1;
    c_addr = 32'h40;
    c_wdata = 32'h1234_5678;
    expq.push_back('{1'b0, 1'b0, WR_BUS});
    #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      c_addr = 32'hFFF0 + 32'(i);
      c_wdata = 32'hFFFF_FFFF;
      c_we = 1'b0;
      #1;
      n_cmp++;
      if ({m_we, m_addr, m_wdata} !==
          {1'b1, 32'h40, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL wr_hold%0d got=%b/%h/%h exp=1/40/12345678",
          i, m_we, m_addr, m_wdata);
      end
      if (i < 4) begin
        n_cmp++;
        if (c_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_early%0d got=%b exp=0",
            i, c_ack);
        end
      end
    end
    n_cmp++;
    if (!c_ack || expq.size() == 0) begin
      n_bad++;
      $display("FAIL wr_sb got=ack%b/q%0d exp=ack1",
        c_ack, expq.size());
    end else begin
      e = expq.pop_front();
      got = {d_ack, d_ack ? d_err : c_err,
        d_ack ? d_rdata : c_rdata};
      want = {e.port, e.err, e.rdata};
      if (got !== want) begin
        n_bad++;
        $display("FAIL wr_sb got=%h exp=%h", got, want);
      end
    end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    n_cmp++;
    if ((mem.exists(32'h40) ? mem[32'h40] : 32'd0)
        !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL wr_mem got=missing exp=12345678");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    c_req = 1'b0;
    c_we = 1'b0;
    c_addr = '0;
    c_wdata = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    test_reset();
    test_core_read();
    test_tie();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_write_path();
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_left got=%0d exp=0", expq.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
